cmac_dot_seq: RTL and testbench

- Dot-product sequencer that drives a complex MAC processing element (cmac PE) from the operand side and collects its accumulated results.
- Accepts a stream of complex operand pairs under valid/ready handshake.
- Issues one pair per cycle into the PE and feeds the running accumulator back on the PE's addend port.
- Presents the final complex dot product on a result handshake.
- Sits between the PE-array operand buffers and the cmac instance in each PE.

---
 rtl/cmac_dot_seq_if.sv | 47 ++++
 rtl/cmac_dot_seq.sv | 129 ++++++++++++
 tb/tb_cmac_dot_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_dot_seq_if.sv
// ---------------------------------------------------------------------------
// cmac_dot_seq_if : operand stream, PE and result bundle for cmac_dot_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cmac_dot_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8
);
  // Command
  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic [4:0]              cfg_shift;
  logic                    busy;
  // Operand stream
  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] in_a;
  logic [2*DATA_WIDTH-1:0] in_b;
  // PE side
  logic                    cmac_mac;
  logic [4:0]              cmac_shift;
  logic [2*DATA_WIDTH-1:0] cmac_opa;
  logic [2*DATA_WIDTH-1:0] cmac_opb;
  logic [2*DATA_WIDTH-1:0] cmac_opc;
  logic [2*DATA_WIDTH-1:0] cmac_opd;
  logic [2*DATA_WIDTH-1:0] cmac_out_add;
  // Result
  logic                    res_valid;
  logic                    res_ready;
  logic [2*DATA_WIDTH-1:0] res_data;

  modport master (
    input  start, cfg_len, cfg_shift, in_valid, in_a, in_b, cmac_out_add, res_ready,
    output busy, in_ready, cmac_mac, cmac_shift, cmac_opa, cmac_opb, cmac_opc,
           cmac_opd, res_valid, res_data
  );

  modport slave (
    output start, cfg_len, cfg_shift, in_valid, in_a, in_b, cmac_out_add, res_ready,
    input  busy, in_ready, cmac_mac, cmac_shift, cmac_opa, cmac_opb, cmac_opc,
           cmac_opd, res_valid, res_data
  );
endinterface

`default_nettype wire

// File: rtl/cmac_dot_seq.sv
// ---------------------------------------------------------------------------
// cmac_dot_seq : streams complex operand pairs into a cmac PE and returns
//                the accumulated complex dot product.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmac_dot_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int CMAC_LAT   = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  cmac_dot_seq_if.master  bus
);

  localparam int CW = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          shift_q, shift_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [CMAC_LAT-1:0] vpipe_q, vpipe_d;
  logic [CMAC_LAT-1:0] vpipe_shift;

  logic in_ready;
  logic fire;
  logic ret;

  assign in_ready = (state_q == ST_RUN) && (cnt_q < len_q);
  assign fire     = in_ready && bus.in_valid;
  assign ret      = vpipe_q[CMAC_LAT-1];

  if (CMAC_LAT == 1) begin : g_pipe_single
    assign vpipe_shift = fire;
  end else begin : g_pipe_multi
    assign vpipe_shift = {vpipe_q[CMAC_LAT-2:0], fire};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      vpipe_q <= vpipe_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    vpipe_d = vpipe_shift;

    if (ret) begin
      acc_d = bus.cmac_out_add;
    end
    if (fire) begin
      cnt_d = cnt_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d   = bus.cfg_len;
          shift_d = bus.cfg_shift;
          cnt_d   = '0;
          acc_d   = '0;
          vpipe_d = '0;
          state_d = (bus.cfg_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (fire && (cnt_q == len_q - LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // ret is a bit of vpipe, so an empty pipe also means no return now
        if (vpipe_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy       = (state_q != ST_IDLE);
    bus.in_ready   = in_ready;
    bus.cmac_mac   = fire;
    bus.cmac_shift = shift_q;
    bus.cmac_opa   = (state_q == ST_RUN) ? bus.in_a : '0;
    bus.cmac_opb   = (state_q == ST_RUN) ? bus.in_b : '0;
    // The PE adds the live accumulator when each issue returns
    bus.cmac_opc   = acc_q;
    bus.cmac_opd   = '0;
    bus.res_valid  = (state_q == ST_DONE);
    bus.res_data   = (state_q == ST_DONE) ? acc_q : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cmac_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_cmac_dot_seq : directed bench for cmac_dot_seq with a 2-cycle PE stub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmac_dot_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cmac_dot_seq_if #(.DATA_WIDTH(16), .LEN_W(8)) bus ();

  cmac_dot_seq #(.DATA_WIDTH(16), .LEN_W(8), .CMAC_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // PE stub: no reset, so stale data keeps flowing across a DUT reset
  logic [31:0] s_opa1, s_opa2;
  logic        s_mac1, s_mac2;

  function automatic logic [31:0] cadd(input logic [31:0] x, input logic [31:0] y);
    return {x[31:16] + y[31:16], x[15:0] + y[15:0]};
  endfunction

  always @(posedge clk) begin
    s_opa1 <= bus.cmac_opa;
    s_mac1 <= bus.cmac_mac;
    s_opa2 <= s_opa1;
    s_mac2 <= s_mac1;
  end

  assign bus.cmac_out_add = (s_mac2 === 1'b1) ? cadd(s_opa2, bus.cmac_opc)
                                              : cadd(bus.cmac_opc, bus.cmac_opd);

  int mac_cnt = 0;
  always @(posedge clk) begin
    if (bus.cmac_mac === 1'b1) mac_cnt <= mac_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]       len;
    logic [4:0]       shift;
    logic [15:0]      vpat;
    logic [7:0][15:0] a_re;
    logic [7:0][15:0] a_im;
    logic [31:0]      exp_res;
    logic [15:0]      exp_macs;
    int               exp_lat;   // start edge to first res_valid edge; -1 = unchecked
  } vec_t;

  vec_t tbl [8];

  // Issue start, feed operands following vpat, wait for the result
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, k, j, base;
    bit got, last_fire;
    bus.cfg_len   = v.len;
    bus.cfg_shift = v.shift;
    bus.start     = 1'b1;
    bus.in_valid  = 1'b0;
    base = mac_cnt;
    cyc = 0; k = 0; j = 0; got = 0; last_fire = 0;
    while (!got && cyc < 800) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (cyc == 1) check({tag, " shift_after_start"}, 64'(bus.cmac_shift), 64'(v.shift));
      if (last_fire) begin
        check({tag, " in_ready_after_last_fire"}, 64'(bus.in_ready), 64'(0));
        last_fire = 0;
      end
      if (bus.res_valid === 1'b1) begin
        got = 1;
      end else if (k < int'(v.len)) begin
        bus.in_valid = v.vpat[j % 16];
        bus.in_a     = {v.a_re[k % 8], v.a_im[k % 8]};
        bus.in_b     = {16'(k), 16'(j)};
        if (bus.in_valid && bus.in_ready === 1'b1) begin
          k++;
          if (k == int'(v.len)) last_fire = 1;
        end
        j++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check({tag, " res_valid_seen"}, 64'(got), 64'(1));
    check({tag, " res_data"}, 64'(bus.res_data), 64'(v.exp_res));
    check({tag, " mac_pulses"}, 64'(mac_cnt - base), 64'(v.exp_macs));
    check({tag, " shift_at_done"}, 64'(bus.cmac_shift), 64'(v.shift));
    if (v.exp_lat >= 0) check({tag, " latency"}, 64'(cyc - 1), 64'(v.exp_lat));
  endtask

  task automatic finish_hs(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check({tag, " res_valid_after_hs"}, 64'(bus.res_valid), 64'(0));
    check({tag, " busy_after_hs"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++) tbl[r] = '0;
    // 1: three back-to-back pairs
    tbl[0].len = 3; tbl[0].shift = 5'd1; tbl[0].vpat = 16'hFFFF;
    for (int i = 0; i < 8; i++) tbl[0].a_re[i] = 16'(i + 1);
    tbl[0].exp_res = 32'h0006_0000; tbl[0].exp_macs = 3; tbl[0].exp_lat = 6;
    // 2: valid gaps 1,0,0,1,1,0,1
    tbl[1].len = 4; tbl[1].vpat = 16'h0059;
    for (int i = 0; i < 8; i++) tbl[1].a_re[i] = 16'd5;
    tbl[1].exp_res = 32'h0014_0000; tbl[1].exp_macs = 4; tbl[1].exp_lat = -1;
    // 3: zero length
    tbl[2].len = 0; tbl[2].shift = 5'd4; tbl[2].vpat = 16'hFFFF;
    tbl[2].exp_res = 32'h0; tbl[2].exp_macs = 0; tbl[2].exp_lat = 0;
    // 6: single pair with shift 9 (also reused after reset)
    tbl[3].len = 1; tbl[3].shift = 5'd9; tbl[3].vpat = 16'hFFFF;
    for (int i = 0; i < 8; i++) tbl[3].a_re[i] = 16'd4;
    tbl[3].exp_res = 32'h0004_0000; tbl[3].exp_macs = 1; tbl[3].exp_lat = 4;
    // complex components with imaginary wrap
    tbl[4].len = 2; tbl[4].shift = 5'd31; tbl[4].vpat = 16'hFFFF;
    tbl[4].a_re[0] = 16'd3;  tbl[4].a_im[0] = 16'hFFFF;
    tbl[4].a_re[1] = 16'd10; tbl[4].a_im[1] = 16'd2;
    tbl[4].exp_res = 32'h000D_0001; tbl[4].exp_macs = 2; tbl[4].exp_lat = 5;
    // eight pairs with irregular gaps
    tbl[5].len = 8; tbl[5].shift = 5'd2; tbl[5].vpat = 16'hA5A5;
    for (int i = 0; i < 8; i++) begin
      tbl[5].a_re[i] = 16'(i + 1);
      tbl[5].a_im[i] = 16'(8 - i);
    end
    tbl[5].exp_res = 32'h0024_0024; tbl[5].exp_macs = 8; tbl[5].exp_lat = -1;
    // maximum length
    tbl[6].len = 8'd255; tbl[6].shift = 5'd0; tbl[6].vpat = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      tbl[6].a_re[i] = 16'd1;
      tbl[6].a_im[i] = 16'd2;
    end
    tbl[6].exp_res = 32'h00FF_01FE; tbl[6].exp_macs = 255; tbl[6].exp_lat = 258;
    // 4: result held under backpressure
    tbl[7].len = 2; tbl[7].shift = 5'd6; tbl[7].vpat = 16'hFFFF;
    tbl[7].a_re[0] = 16'd7; tbl[7].a_re[1] = 16'd9;
    tbl[7].exp_res = 32'h0010_0000; tbl[7].exp_macs = 2; tbl[7].exp_lat = 5;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_shift = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready",   64'(bus.in_ready),   64'(0));
    check("reset res_valid",  64'(bus.res_valid),  64'(0));
    check("reset res_data",   64'(bus.res_data),   64'(0));
    check("reset cmac_mac",   64'(bus.cmac_mac),   64'(0));
    check("reset cmac_shift", 64'(bus.cmac_shift), 64'(0));
    check("reset cmac_opc",   64'(bus.cmac_opc),   64'(0));
    check("reset busy",       64'(bus.busy),       64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      run_vec(tbl[r], $sformatf("vec%0d", r));
      finish_hs($sformatf("vec%0d", r));
      check($sformatf("vec%0d opd_zero", r), 64'(bus.cmac_opd), 64'(0));
    end

    // Backpressure: result stable, start ignored, shift unchanged
    bus.res_ready = 1'b0;
    run_vec(tbl[7], "hold");
    for (int i = 0; i < 5; i++) begin
      bus.start     = (i == 1);
      bus.cfg_len   = 8'd3;
      bus.cfg_shift = 5'd2;
      @(negedge clk);
      check($sformatf("hold res_valid c%0d", i), 64'(bus.res_valid), 64'(1));
      check($sformatf("hold res_data c%0d", i),  64'(bus.res_data),  64'(32'h0010_0000));
      check($sformatf("hold in_ready c%0d", i),  64'(bus.in_ready),  64'(0));
    end
    bus.start = 1'b0;
    check("hold shift_kept", 64'(bus.cmac_shift), 64'(6));
    finish_hs("hold");
    check("idle shift_kept", 64'(bus.cmac_shift), 64'(6));

    // Reset in the middle of a 5-long run after three issues
    bus.cfg_len = 8'd5; bus.cfg_shift = 5'd3; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = {16'(i + 1), 16'd0};
    end
    @(negedge clk);
    check("midrun opc_nonzero", 64'(bus.cmac_opc), 64'(32'h0001_0000));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async busy",       64'(bus.busy),       64'(0));
    check("async in_ready",   64'(bus.in_ready),   64'(0));
    check("async cmac_mac",   64'(bus.cmac_mac),   64'(0));
    check("async cmac_shift", 64'(bus.cmac_shift), 64'(0));
    check("async cmac_opc",   64'(bus.cmac_opc),   64'(0));
    check("async res_valid",  64'(bus.res_valid),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_vec(tbl[3], "post_reset");
    finish_hs("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
